sobel_edge_filter: RTL and testbench
====================================

// Module: sobel_edge_filter
// PURPOSE
//  Streaming 3x3 Sobel edge-magnitude filter. Sits directly downstream of to_greyscale:
//  consumes its 12-bit grey pixel stream (oDATA/mDVAL) and emits one 12-bit edge magnitude
//  per accepted pixel, feeding the display/SDRAM write path. No back-pressure; fixed latency.
// PARAMETERS
//  LINE_WIDTH   640   grey pixels per line (valid pixels from to_greyscale per line)
//  FRAME_HEIGHT 480   lines per frame; row counter wraps after this many lines
//  THRESHOLD    12'h200  binarisation level (used only with SOBEL_THRESH_EN)
// PORTS
//  iCLK    in   1   clock
//  iRST    in   1   asynchronous reset, active-high
//  iDATA   in   12  grey pixel, sampled when iDVAL=1
//  iDVAL   in   1   input pixel valid (connect to to_greyscale mDVAL)
//  oDATA   out  12  edge magnitude (or binarised value, see CONFIGURATION)
//  oDVAL   out  1   oDATA valid
// BEHAVIOUR
//  - Reset (async, iRST=1): oDATA=0, oDVAL=0, col/row counters=0, window regs=0, pipe valids=0;
//    line-buffer contents need not be cleared (masked by border rule). Reset mid-frame restarts at (0,0).
//  - Raster order, row-major. col counter 0..LINE_WIDTH-1 incs per iDVAL; wrap to 0 incs row;
//    row wraps to 0 after FRAME_HEIGHT-1. Counters/window/line buffers advance ONLY on iDVAL=1;
//    gaps in iDVAL of any length change no state except pipeline bubbles.
//  - Window: 3x3 p[r][c], r=0 oldest line; right column p[*][2] = {linebuf2 out, linebuf1 out, iDATA}
//    for current pixel at (row,col); window is the 3x3 whose bottom-right is (row,col).
//  - Pipeline, no stall, bubbles propagate:
//    S1 (edge on which iDVAL sampled): window shift, line-buffer push, border flag latched
//    S2: Gx=(p02+2p12+p22)-(p00+2p10+p20), Gy=(p20+2p21+p22)-(p00+2p01+p02); 15-bit signed each
//    S3: mag=|Gx|+|Gy| (16-bit unsigned); oDATA=(mag>4095)?12'hFFF:mag[11:0]; border->0
//    oDVAL is iDVAL delayed by exactly 3 clock edges; exactly one oDVAL per iDVAL.
//  - Border: flag=1 when row<2 or col<2; output forced to 12'h000 (oDVAL still 1).
//  - oDATA holds its last value while oDVAL=0.
// CONFIGURATION
//  SOBEL_THRESH_EN defined: S3 output oDATA = (sat_mag >= THRESHOLD) ? 12'hFFF : 12'h000;
//    border still 0; latency unchanged.
//  Not defined: oDATA = saturated magnitude; THRESHOLD ignored.
// STRUCTURE
//  - sobel_pkg: typedef pixel_t (logic [11:0]), grad_t (logic signed [14:0]), mag_t (logic [15:0]),
//    localparam PIX_MAX=12'hFFF.
//  - Sub-module sobel_line_buffer (params WIDTH=12, DEPTH=LINE_WIDTH; iCLK, iRST, iEN, iDATA, oDATA):
//    DEPTH-deep shift register advanced on iEN; instantiated twice, chained.
// TESTING
//  1 Reset: iRST=1 mid-stream -> oDATA=0, oDVAL=0 next edge; after release first output is border (0).
//  2 Flat frame 12'h100, 640x480, iDVAL=1 continuous -> 307200 oDVAL pulses, all oDATA=12'h000,
//    first oDVAL 3 edges after first iDVAL.
//  3 Vertical step: cols<320 =0, cols>=320 =12'h0FF -> rows>=2: col 320 and 321 = 12'h3FC, others 0.
//  4 Saturation: step 0 -> 12'hFFF -> Gx=16380, step columns oDATA=12'hFFF; rows 0,1 and cols 0,1 = 0.
//  5 iDVAL gaps: test 3 with random 0-5 cycle gaps -> oDATA sequence identical to gapless run.
//  6 SOBEL_THRESH_EN, THRESHOLD=12'h200: test 3 stimulus -> step columns 12'hFFF, all else 0;
//    step height 12'h07F (Gx=508) -> all 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel edge filter.
// Optional feature macro: SOBEL_THRESH_EN (binarised output).
package sobel_pkg;

  typedef logic [11:0] pixel_t;
  typedef logic signed [14:0] grad_t;
  typedef logic [15:0] mag_t;

  localparam pixel_t PIX_MAX = 12'hFFF;

  // Zero-extend a pixel into the signed gradient domain.
  function automatic grad_t ext(input pixel_t p);
    return $signed({3'b000, p});
  endfunction

  // Absolute value of a gradient, widened to the magnitude type.
  function automatic mag_t abs_mag(input grad_t g);
    grad_t n;
    n = -g;
    return g[14] ? mag_t'({1'b0, n}) : mag_t'({1'b0, g});
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line delay for the Sobel window: DEPTH-deep shift register
// that advances only on iEN, so idle cycles leave it untouched.
module sobel_line_buffer #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 640
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iEN,
  input  logic [WIDTH-1:0] iDATA,
  output logic [WIDTH-1:0] oDATA
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  // Shift one sample per accepted pixel; tail is the pixel one line back.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else if (iEN) begin
      r_sr[0] <= iDATA;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign oDATA = r_sr[DEPTH-1];

endmodule

// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel edge magnitude, three-stage fixed latency.
// Define SOBEL_THRESH_EN to binarise the output against THRESHOLD.
module sobel_edge_filter
  import sobel_pkg::*;
#(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480
`ifdef SOBEL_THRESH_EN
  ,
  parameter pixel_t THRESHOLD = 12'h200
`endif
) (
  input  logic   iCLK,
  input  logic   iRST,
  input  pixel_t iDATA,
  input  logic   iDVAL,
  output pixel_t oDATA,
  output logic   oDVAL
);

  localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  pixel_t w_lb1;
  pixel_t w_lb2;

  pixel_t r_win [3][3];
  logic   r_v1;
  logic   r_b1;

  grad_t  w_gx;
  grad_t  w_gy;
  grad_t  r_gx;
  grad_t  r_gy;
  logic   r_v2;
  logic   r_b2;

  mag_t   w_mag;
  pixel_t w_sat;
  pixel_t w_res;
  pixel_t r_odata;
  logic   r_odval;

  sobel_line_buffer #(
    .WIDTH (12),
    .DEPTH (LINE_WIDTH)
  ) u_lb1 (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iEN   (iDVAL),
    .iDATA (iDATA),
    .oDATA (w_lb1)
  );

  sobel_line_buffer #(
    .WIDTH (12),
    .DEPTH (LINE_WIDTH)
  ) u_lb2 (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iEN   (iDVAL),
    .iDATA (w_lb1),
    .oDATA (w_lb2)
  );

  // Raster position of the pixel being accepted; wraps per line and frame.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_col <= '0;
      r_row <= '0;
    end else if (iDVAL) begin
      if (r_col == CW'(LINE_WIDTH - 1)) begin
        r_col <= '0;
        if (r_row == RW'(FRAME_HEIGHT - 1)) r_row <= '0;
        else r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // S1: shift the window left and load the new right-hand column.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
      r_v1 <= 1'b0;
      r_b1 <= 1'b0;
    end else begin
      r_v1 <= iDVAL;
      if (iDVAL) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_lb2;
        r_win[1][2] <= w_lb1;
        r_win[2][2] <= iDATA;
        r_b1 <= (r_row < RW'(2)) || (r_col < CW'(2));
      end
    end
  end

  // Horizontal and vertical gradients of the current window.
  always_comb begin
    w_gx = (ext(r_win[0][2]) + (ext(r_win[1][2]) <<< 1) + ext(r_win[2][2]))
         - (ext(r_win[0][0]) + (ext(r_win[1][0]) <<< 1) + ext(r_win[2][0]));
    w_gy = (ext(r_win[2][0]) + (ext(r_win[2][1]) <<< 1) + ext(r_win[2][2]))
         - (ext(r_win[0][0]) + (ext(r_win[0][1]) <<< 1) + ext(r_win[0][2]));
  end

  // S2: register gradients alongside the valid and border flags.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_gx <= '0;
      r_gy <= '0;
      r_v2 <= 1'b0;
      r_b2 <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_gx <= w_gx;
        r_gy <= w_gy;
        r_b2 <= r_b1;
      end
    end
  end

  // L1 magnitude, saturated to the pixel range, optionally binarised.
  always_comb begin
    w_mag = abs_mag(r_gx) + abs_mag(r_gy);
    w_sat = (w_mag > 16'd4095) ? PIX_MAX : w_mag[11:0];
`ifdef SOBEL_THRESH_EN
    w_res = (w_sat >= THRESHOLD) ? PIX_MAX : '0;
`else
    w_res = w_sat;
`endif
  end

  // S3: output register; border pixels read as zero, data held when idle.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_odata <= '0;
      r_odval <= 1'b0;
    end else begin
      r_odval <= r_v2;
      if (r_v2) r_odata <= r_b2 ? '0 : w_res;
    end
  end

  assign oDATA = r_odata;
  assign oDVAL = r_odval;

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Scoreboard bench for sobel_edge_filter on a reduced 16x6 frame.
// Build with SOBEL_THRESH_EN defined to exercise the binarised output.
module tb_sobel_edge_filter;
  import sobel_pkg::*;

  localparam int LW = 16;
  localparam int FH = 6;
  localparam int STEP = 8;

  typedef struct {
    pixel_t d;
    int     t;
    int     r;
    int     c;
  } exp_t;

  logic   iCLK = 1'b0;
  logic   iRST = 1'b1;
  pixel_t iDATA = '0;
  logic   iDVAL = 1'b0;
  pixel_t oDATA;
  logic   oDVAL;

  exp_t   q[$];
  int     cyc = 0;
  int     nvec = 0;
  int     nmis = 0;
  pixel_t last = '0;

  sobel_edge_filter #(
`ifdef SOBEL_THRESH_EN
    .THRESHOLD    (12'h200),
`endif
    .LINE_WIDTH   (LW),
    .FRAME_HEIGHT (FH)
  ) dut (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iDATA (iDATA),
    .iDVAL (iDVAL),
    .oDATA (oDATA),
    .oDVAL (oDVAL)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc++;

  // Hand-derived result for a step of height v: the two columns whose
  // window straddles the step see Gx = 4*v, Gy = 0; everything else is 0.
  function automatic pixel_t step_exp(input pixel_t v, input int r, input int c);
    int m;
    pixel_t s;
    if (r < 2 || c < 2) return 12'h000;
    if (c != STEP && c != STEP + 1) return 12'h000;
    m = 4 * int'(v);
    s = (m > 4095) ? 12'hFFF : pixel_t'(m);
`ifdef SOBEL_THRESH_EN
    return (s >= 12'h200) ? 12'hFFF : 12'h000;
`else
    return s;
`endif
  endfunction

  // kind 0: flat frame of v; kind 1: vertical step 0 -> v at STEP.
  task automatic drive(input int kind, input pixel_t v,
                       input bit gaps, input int npx);
    int n;
    exp_t e;
    n = 0;
    for (int r = 0; r < FH; r++) begin
      for (int c = 0; c < LW; c++) begin
        if (n < npx) begin
          if (gaps) begin
            repeat ($urandom_range(0, 5)) begin
              iDVAL = 1'b0;
              @(posedge iCLK); #1;
            end
          end
          iDATA = (kind == 0) ? v : ((c >= STEP) ? v : 12'h000);
          iDVAL = 1'b1;
          e.d = (kind == 0) ? 12'h000 : step_exp(v, r, c);
          e.t = cyc + 3;
          e.r = r;
          e.c = c;
          q.push_back(e);
          @(posedge iCLK); #1;
          n++;
        end
      end
    end
    iDVAL = 1'b0;
  endtask

  // Monitor: pops one expectation per output beat, checks hold when idle.
  always @(negedge iCLK) begin
    exp_t e;
    if (iRST) begin
      last = '0;
    end else if (oDVAL) begin
      nvec++;
      if (q.size() == 0) begin
        nmis++;
        $display("FAIL extra_output: oDATA=%h with no pixel pending", oDATA);
      end else begin
        e = q.pop_front();
        if (oDATA !== e.d || cyc != e.t) begin
          nmis++;
          $display("FAIL pixel r%0d c%0d: got %h at cyc %0d, want %h at cyc %0d",
                   e.r, e.c, oDATA, cyc, e.d, e.t);
        end
      end
      last = oDATA;
    end else begin
      nvec++;
      if (oDATA !== last) begin
        nmis++;
        $display("FAIL hold: oDATA=%h while idle, want %h", oDATA, last);
      end
    end
  end

  task automatic chk_reset(input string name);
    nvec++;
    if (oDATA !== 12'h000 || oDVAL !== 1'b0) begin
      nmis++;
      $display("FAIL %s: oDATA=%h oDVAL=%b, want 000/0", name, oDATA, oDVAL);
    end
  endtask

  initial begin
    #1 chk_reset("reset_state");
    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b0;

    // Partial step frame, then reset while oDATA holds a nonzero result.
    drive(1, 12'h0FF, 1'b0, 2 * LW + STEP + 2);
    repeat (5) @(posedge iCLK);
    #1 iRST = 1'b1;
    #1 chk_reset("reset_midstream");
    q.delete();
    repeat (2) @(posedge iCLK);
    #1 iRST = 1'b0;

    // Flat frames, including a frame wrap.
    drive(0, 12'h100, 1'b0, LW * FH);
    drive(0, 12'h100, 1'b0, LW * FH);
    // Step frames; second one checks border rows after wrap.
    drive(1, 12'h0FF, 1'b0, LW * FH);
    drive(1, 12'h0FF, 1'b0, LW * FH);
    // Saturating step.
    drive(1, 12'hFFF, 1'b0, LW * FH);
    // Step with random valid gaps.
    drive(1, 12'h0FF, 1'b1, LW * FH);
    // Small step, below threshold when binarised.
    drive(1, 12'h07F, 1'b0, LW * FH);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge iCLK);
    repeat (3) @(posedge iCLK);
    nvec++;
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL drain: %0d outputs missing, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
